// File: rtl/ah_decoder_pkg.sv
// Shared types and constants for the programmable range decoder.
// Window bounds are stored at WIN_W bits; the decoder zero-extends narrower addresses.
package ah_decoder_pkg;

  localparam int DEF_ADDR_W      = 96;
  localparam int DEF_NUM_CLIENTS = 15;
  localparam int DEF_ERR_CNT_W   = 16;

  // Widest address the window table can hold; ADDR_W must not exceed it.
  localparam int WIN_W = 128;

  typedef struct packed {
    logic [WIN_W-1:0] bom;
    logic [WIN_W-1:0] tom;
    logic             enable;
  } window_t;

  // bom > tom guarantees a reset window can never hit, even if enabled later by mistake.
  localparam window_t WIN_RESET = '{bom: '1, tom: '0, enable: 1'b0};

endpackage

// File: rtl/ah_range_decoder_pipe_if.sv
// Ingress, egress, configuration and error-counter signals of the range decoder.
// The master drives lookups and configuration; the slave is the decoder.
interface ah_range_decoder_pipe_if #(
  parameter int ADDR_W      = 96,
  parameter int NUM_CLIENTS = 15,
  parameter int ID_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1,
  parameter int ERR_CNT_W   = 16
);
  logic                   ingress_valid;
  logic                   ingress_ready;
  logic [ADDR_W-1:0]      ingress_pkt_field;
  logic                   egress_valid;
  logic                   egress_ready;
  logic [NUM_CLIENTS-1:0] decoded_onehot;
  logic [ID_W-1:0]        decoded_binary;
  logic                   dec_err;
  logic                   cfg_wr_en;
  logic [ID_W-1:0]        cfg_idx;
  logic [ADDR_W-1:0]      cfg_bom;
  logic [ADDR_W-1:0]      cfg_tom;
  logic                   cfg_enable;
  logic [ERR_CNT_W-1:0]   err_cnt;
  logic                   err_cnt_clr;

  modport master (
    output ingress_valid, ingress_pkt_field, egress_ready,
    output cfg_wr_en, cfg_idx, cfg_bom, cfg_tom, cfg_enable, err_cnt_clr,
    input  ingress_ready, egress_valid, decoded_onehot, decoded_binary, dec_err, err_cnt
  );

  modport slave (
    input  ingress_valid, ingress_pkt_field, egress_ready,
    input  cfg_wr_en, cfg_idx, cfg_bom, cfg_tom, cfg_enable, err_cnt_clr,
    output ingress_ready, egress_valid, decoded_onehot, decoded_binary, dec_err, err_cnt
  );
endinterface

// File: rtl/ah_prio_encoder.sv
// Lowest-index-wins priority encoder: one-hot, binary index and a none-hit flag.
module ah_prio_encoder #(
  parameter int NUM_CLIENTS = 15,
  parameter int ID_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic [NUM_CLIENTS-1:0] i_hit,
  output logic [NUM_CLIENTS-1:0] o_onehot,
  output logic [ID_W-1:0]        o_binary,
  output logic                   o_none
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    o_onehot = '0;
    o_binary = '0;
    o_none   = 1'b1;
    // Scanning downward means the lowest hitting index is written last and wins.
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (i_hit[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_binary    = ID_W'(i);
        o_none      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ah_range_decoder_pipe.sv
// Two-stage pipelined address-window decoder with run-time programmable windows,
// valid/ready flow control on both sides and a saturating decode-error counter.
module ah_range_decoder_pipe
  import ah_decoder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int ID_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1,
  parameter int ERR_CNT_W   = DEF_ERR_CNT_W
) (
  input logic                  clk,
  input logic                  rst_n,
  ah_range_decoder_pipe_if.slave bus
);

  window_t                r_win [NUM_CLIENTS];
  logic [WIN_W-1:0]       w_field_ext;
  logic [NUM_CLIENTS-1:0] w_hit;
  logic [NUM_CLIENTS-1:0] w_onehot;
  logic [ID_W-1:0]        w_binary;
  logic                   w_none;
  logic                   w_s1_ready;
  logic                   w_s2_ready;
  logic                   w_egress_fire;

  logic                   r_s1_valid;
  logic [NUM_CLIENTS-1:0] r_s1_hit;
  logic                   r_s2_valid;
  logic [NUM_CLIENTS-1:0] r_s2_onehot;
  logic [ID_W-1:0]        r_s2_binary;
  logic                   r_s2_err;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  // Window table: a write lands at the edge of its cycle, so same-cycle lookups see old values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the window table is reset on purpose; its reset value (all disabled) is functional state.
      for (int i = 0; i < NUM_CLIENTS; i++) r_win[i] <= WIN_RESET;
    end else if (bus.cfg_wr_en) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (bus.cfg_idx == ID_W'(i)) begin
          r_win[i].bom    <= WIN_W'(bus.cfg_bom[ADDR_W-1:0]);
          r_win[i].tom    <= WIN_W'(bus.cfg_tom[ADDR_W-1:0]);
          r_win[i].enable <= bus.cfg_enable;
        end
      end
    end
  end

  assign w_field_ext = WIN_W'(bus.ingress_pkt_field[ADDR_W-1:0]);

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      w_hit[i] = r_win[i].enable && (r_win[i].bom <= w_field_ext) && (w_field_ext <= r_win[i].tom);
    end
  end

  ah_prio_encoder #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .ID_W        (ID_W)
  ) u_prio_encoder (
    .i_hit    (r_s1_hit),
    .o_onehot (w_onehot),
    .o_binary (w_binary),
    .o_none   (w_none)
  );

  // Each stage can load when empty or when the stage after it is draining this cycle.
  assign w_s2_ready    = !r_s2_valid || bus.egress_ready;
  assign w_s1_ready    = !r_s1_valid || w_s2_ready;
  assign w_egress_fire = r_s2_valid && bus.egress_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      r_s1_valid  <= 1'b0;
      r_s1_hit    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_onehot <= '0;
      r_s2_binary <= '0;
      r_s2_err    <= 1'b0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= bus.ingress_valid;
        if (bus.ingress_valid) r_s1_hit <= w_hit;
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_onehot <= w_onehot;
          r_s2_binary <= w_binary;
          r_s2_err    <= w_none;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (bus.err_cnt_clr) begin
      r_err_cnt <= '0;
    end else if (w_egress_fire && r_s2_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.ingress_ready  = w_s1_ready;
  assign bus.egress_valid   = r_s2_valid;
  assign bus.decoded_onehot = r_s2_onehot;
  assign bus.decoded_binary = r_s2_binary;
  assign bus.dec_err        = r_s2_err;
  assign bus.err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_ah_range_decoder_pipe.sv
// Directed bench for ah_range_decoder_pipe: table-driven streaming lookups plus
// hand-written sequences for backpressure, config races, reset and counter saturation.
module tb_ah_range_decoder_pipe;

  localparam int ADDR_W      = 96;
  localparam int NUM_CLIENTS = 15;
  localparam int ID_W        = 4;
  localparam int ERR_CNT_W   = 4;
  localparam int NV          = 20;

  typedef struct {
    logic [ADDR_W-1:0] field;
    bit                err;
    int                bin;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [0:NV-1];

  ah_range_decoder_pipe_if #(
    .ADDR_W(ADDR_W), .NUM_CLIENTS(NUM_CLIENTS), .ID_W(ID_W), .ERR_CNT_W(ERR_CNT_W)
  ) bus ();

  ah_range_decoder_pipe #(
    .ADDR_W(ADDR_W), .NUM_CLIENTS(NUM_CLIENTS), .ID_W(ID_W), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic [ADDR_W-1:0] bom, input logic [ADDR_W-1:0] tom,
                           input bit en);
    bus.cfg_wr_en  = 1'b1;
    bus.cfg_idx    = ID_W'(idx);
    bus.cfg_bom    = bom;
    bus.cfg_tom    = tom;
    bus.cfg_enable = en;
    tick();
    bus.cfg_wr_en  = 1'b0;
  endtask

  task automatic check_result(input string tag, input bit err, input int bin);
    logic [63:0] exp_oh;
    exp_oh = err ? 64'd0 : (64'd1 << bin);
    check({tag, " valid"},  64'(bus.egress_valid),   64'd1);
    check({tag, " dec_err"}, 64'(bus.dec_err),       64'(err));
    check({tag, " binary"}, 64'(bus.decoded_binary), err ? 64'd0 : 64'(bin));
    check({tag, " onehot"}, 64'(bus.decoded_onehot), exp_oh);
  endtask

  // Back-to-back lookups with egress_ready high: result i appears two steps after it is driven.
  task automatic run_stream(input int lo, input int hi);
    int n;
    n = hi - lo + 1;
    bus.egress_ready = 1'b1;
    for (int s = 0; s < n + 2; s++) begin
      if (s >= 2) check_result($sformatf("v%0d", lo + s - 2), vecs[lo+s-2].err, vecs[lo+s-2].bin);
      if (s < n) begin
        bus.ingress_valid     = 1'b1;
        bus.ingress_pkt_field = vecs[lo+s].field;
        #1;
        check($sformatf("v%0d ingress_ready", lo + s), 64'(bus.ingress_ready), 64'd1);
      end else begin
        bus.ingress_valid = 1'b0;
      end
      tick();
    end
    check($sformatf("stream %0d..%0d drained", lo, hi), 64'(bus.egress_valid), 64'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] bp_field [0:7];
    int                acc;

    vecs[0]  = '{96'h0,    1, 0};
    vecs[1]  = '{96'h3FFF, 1, 0};
    vecs[2]  = '{96'h4000, 0, 3};
    vecs[3]  = '{96'h5FFF, 0, 3};
    vecs[4]  = '{96'h6000, 1, 0};
    vecs[5]  = '{96'h1800, 0, 1};
    vecs[6]  = '{96'h2800, 0, 2};
    vecs[7]  = '{96'h0000, 0, 1};
    vecs[8]  = '{96'h3000, 1, 0};
    vecs[9]  = '{96'h1FFF, 0, 1};
    vecs[10] = '{96'h9000, 1, 0};
    vecs[11] = '{96'h8800, 1, 0};
    vecs[12] = '{96'h10,   0, 0};
    vecs[13] = '{96'h11,   1, 0};
    vecs[14] = '{96'h0F,   1, 0};
    vecs[15] = '{96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0, 6};
    vecs[16] = '{96'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 0};
    vecs[17] = '{96'h10,   1, 0};
    vecs[18] = '{96'h4100, 1, 0};
    vecs[19] = '{96'h1800, 1, 0};

    for (int i = 0; i < 8; i++) bp_field[i] = 96'h0;
    bp_field[0] = 96'h4100;
    bp_field[1] = 96'h1100;

    bus.ingress_valid     = 1'b0;
    bus.ingress_pkt_field = '0;
    bus.egress_ready      = 1'b0;
    bus.cfg_wr_en         = 1'b0;
    bus.cfg_idx           = '0;
    bus.cfg_bom           = '0;
    bus.cfg_tom           = '0;
    bus.cfg_enable        = 1'b0;
    bus.err_cnt_clr       = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset egress_valid", 64'(bus.egress_valid), 64'd0);
    check("reset onehot", 64'(bus.decoded_onehot), 64'd0);
    check("reset binary", 64'(bus.decoded_binary), 64'd0);
    check("reset dec_err", 64'(bus.dec_err), 64'd0);
    check("reset err_cnt", 64'(bus.err_cnt), 64'd0);
    check("reset ingress_ready", 64'(bus.ingress_ready), 64'd1);

    // 1: no windows programmed -> decode error
    run_stream(0, 0);
    check("t1 err_cnt", 64'(bus.err_cnt), 64'd1);

    // 2: single window, boundary addresses streamed back to back
    bus.err_cnt_clr = 1'b1;
    tick();
    bus.err_cnt_clr = 1'b0;
    check("t2 err_cnt cleared", 64'(bus.err_cnt), 64'd0);
    cfg_write(3, 96'h4000, 96'h5FFF, 1'b1);
    run_stream(1, 4);
    check("t2 err_cnt", 64'(bus.err_cnt), 64'd2);

    // 3: overlapping windows, lowest index wins
    cfg_write(1, 96'h0, 96'h1FFF, 1'b1);
    cfg_write(2, 96'h1000, 96'h2FFF, 1'b1);
    run_stream(5, 9);

    // 4: backpressure holds two lookups, then drains in order
    bus.egress_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      bus.ingress_valid     = 1'b1;
      bus.ingress_pkt_field = bp_field[acc];
      #1;
      if (bus.ingress_ready) acc++;
      if (c >= 2) begin
        check($sformatf("t4 c%0d ingress_ready", c), 64'(bus.ingress_ready), 64'd1 - 64'd1);
        check_result($sformatf("t4 c%0d held", c), 1'b0, 3);
      end
      tick();
    end
    check("t4 accepted", 64'(acc), 64'd2);
    bus.ingress_valid = 1'b0;
    bus.egress_ready  = 1'b1;
    #1;
    check_result("t4 drain0", 1'b0, 3);
    tick();
    check_result("t4 drain1", 1'b0, 1);
    tick();
    check("t4 drained", 64'(bus.egress_valid), 64'd0);

    // 5: config write racing a lookup, plus empty/disabled/out-of-range/full-width windows
    cfg_write(1, 96'h0, 96'h1FFF, 1'b0);
    cfg_write(4, 96'h9000, 96'h8000, 1'b1);
    cfg_write(5, 96'h9000, 96'h9FFF, 1'b0);
    cfg_write(6, 96'h8000_0000_0000_0000_0000_0000, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1);
    bus.egress_ready      = 1'b1;
    bus.cfg_wr_en         = 1'b1;
    bus.cfg_idx           = 4'd0;
    bus.cfg_bom           = 96'h10;
    bus.cfg_tom           = 96'h10;
    bus.cfg_enable        = 1'b1;
    bus.ingress_valid     = 1'b1;
    bus.ingress_pkt_field = 96'h10;
    tick();
    bus.cfg_wr_en = 1'b0;
    tick();
    bus.ingress_valid = 1'b0;
    check_result("t5 race old", 1'b1, 0);
    tick();
    check_result("t5 race new", 1'b0, 0);
    tick();
    check("t5 race drained", 64'(bus.egress_valid), 64'd0);
    cfg_write(15, 96'h0, 96'hFFFF, 1'b1);
    run_stream(10, 16);

    // 6a: reset with two lookups in flight
    bus.egress_ready      = 1'b0;
    bus.ingress_valid     = 1'b1;
    bus.ingress_pkt_field = 96'h4100;
    tick();
    bus.ingress_pkt_field = 96'h1100;
    tick();
    bus.ingress_valid = 1'b0;
    check("t6 in flight", 64'(bus.egress_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6 reset egress_valid", 64'(bus.egress_valid), 64'd0);
    check("t6 reset onehot", 64'(bus.decoded_onehot), 64'd0);
    check("t6 reset err_cnt", 64'(bus.err_cnt), 64'd0);
    check("t6 reset ingress_ready", 64'(bus.ingress_ready), 64'd1);
    bus.egress_ready = 1'b1;
    tick();
    check("t6 nothing emitted", 64'(bus.egress_valid), 64'd0);
    run_stream(17, 19);
    check("t6 err_cnt after reset", 64'(bus.err_cnt), 64'd3);

    // 6b: saturation, then clear coinciding with an increment
    bus.ingress_valid     = 1'b1;
    bus.ingress_pkt_field = 96'h0;
    for (int c = 0; c < 20; c++) tick();
    check("t6 saturated", 64'(bus.err_cnt), 64'd15);
    bus.ingress_valid = 1'b0;
    bus.err_cnt_clr   = 1'b1;
    check("t6 clr egress_valid", 64'(bus.egress_valid), 64'd1);
    check("t6 clr dec_err", 64'(bus.dec_err), 64'd1);
    tick();
    bus.err_cnt_clr = 1'b0;
    check("t6 clear wins", 64'(bus.err_cnt), 64'd0);
    tick();
    check("t6 count after clear", 64'(bus.err_cnt), 64'd1);
    check("t6 final drained", 64'(bus.egress_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ah_range_decoder_pipe.md
Name: ah_range_decoder_pipe

Overview:
Parametrised, pipelined successor to the fixed-range 96-bit client decoder. It maps an ingress packet field onto one of NUM_CLIENTS address windows. Windows are run-time programmable rather than hard-wired constants. The block sits between the ingress packet parser and the client arbiters, with valid/ready flow control on both sides. It reports the client as both one-hot and binary, flags decode errors, and counts errored lookups.

Parameters:
ADDR_W, 96, width of ingress_pkt_field and of each window bound
NUM_CLIENTS, 15, number of decode windows/clients (1..64)
ID_W, $clog2(NUM_CLIENTS) (min 1), width of client index and binary output
ERR_CNT_W, 16, width of saturating decode-error counter

Ports:
clk  in  1  single clock; all logic on the rising edge
rst_n  in  1  synchronous reset, active-low
ingress_valid  in  1  lookup request valid
ingress_ready  out  1  block can accept a lookup this cycle
ingress_pkt_field  in  ADDR_W  address/field to decode
egress_valid  out  1  decode result valid
egress_ready  in  1  downstream accepts result
decoded_onehot  out  NUM_CLIENTS  one-hot winning client (all zero on error)
decoded_binary  out  ID_W  binary index of winning client (0 on error)
dec_err  out  1  no enabled window matched
cfg_wr_en  in  1  window programming strobe
cfg_idx  in  ID_W  window being programmed
cfg_bom  in  ADDR_W  bottom of memory (inclusive low bound)
cfg_tom  in  ADDR_W  top of memory (inclusive high bound)
cfg_enable  in  1  window enable
err_cnt  out  ERR_CNT_W  saturating count of errored results
err_cnt_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Reset (rst_n=0 at a clock edge): all windows bom='1, tom='0, enable=0; both pipeline valids 0; egress_valid=0, decoded_onehot=0, decoded_binary=0, dec_err=0, err_cnt=0. ingress_ready=1 in the first cycle after reset. Reset mid-operation discards in-flight lookups without emitting them.
- Match rule: client i hits when enable[i] && bom[i] <= field <= tom[i]. Comparison is unsigned, full ADDR_W width. A window with bom>tom never hits. A window with bom==tom hits exactly one address.
- Overlap: the lowest index wins. decoded_onehot has at most one bit set.
- dec_err=1 iff no window hits. In that case onehot=0 and binary=0.
- Pipeline: two stages, so latency is 2 cycles from ingress handshake to egress_valid. Full throughput is 1 lookup/cycle.
  - S1 registers the field and the raw hit vector; the compare uses the window registers current in that cycle.
  - S2 registers priority-encoded onehot/binary/err.
- Flow control: a stage advances when it is empty or its downstream consumer accepts.
  - ingress_ready = !s1_valid || s1_advance. ingress_ready is combinational from egress_ready through at most two stages, with no bubbles.
  - Egress outputs hold stable while egress_valid && !egress_ready.
- Config write: a write in cycle N updates window cfg_idx at edge N. A lookup compared in cycle N uses the old values; from N+1 it uses the new. cfg_idx >= NUM_CLIENTS is ignored. Writes are accepted regardless of stalls. Lookups already in S1/S2 are not re-evaluated.
- err_cnt increments by 1 on each egress handshake with dec_err=1 and saturates at all-ones.
  - err_cnt_clr has priority: if clear and increment coincide, the result is 0.

Decomposition:
- Shared package ah_decoder_pkg: default ADDR_W/NUM_CLIENTS, a window struct typedef {bom, tom, enable}, and the window reset constants (bom all-ones, tom zero).
- One sub-module: ah_prio_encoder (parametrised NUM_CLIENTS). Input: hit vector. Outputs: one-hot, binary and none-flag, all combinational.
- Window registers and pipeline stay in the top level.

Test Plan:
1. Reset, no config: send field 0x0 -> 2 cycles later egress_valid=1, dec_err=1, onehot=0, binary=0; err_cnt=1 after handshake.
2. Program window 3 = [0x4000,0x5FFF] enabled. Stream 0x3FFF, 0x4000, 0x5FFF, 0x6000 back-to-back with egress_ready=1 -> results err, client 3, client 3, err on consecutive cycles; err_cnt=2.
3. Overlap: window 1 = [0x0,0x1FFF] and window 2 = [0x1000,0x2FFF]. Lookup 0x1800 -> onehot=0b110 masked to 0b010, binary=1.
4. Backpressure: hold egress_ready=0 for 5 cycles while ingress_valid=1 -> exactly 2 lookups accepted, ingress_ready=0 after that, egress outputs stable. Release -> in-order delivery, no loss or duplication.
5. Config race: a write enabling window 0 = [0x10,0x10] in the same cycle a lookup of 0x10 is compared -> err. The next lookup of 0x10 -> client 0. Also a write with cfg_idx=15 -> no effect.
6. Reset mid-stream with 2 lookups in flight -> egress_valid=0 next cycle, all windows disabled. err_cnt saturation: preload via repeated errors at ERR_CNT_W=4 -> holds at 15; clear concurrent with increment -> 0.
